// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer of mips_cpu_harvard.
// Defines the op encoding, the sequencer state encoding and the default iteration count.
package mips_cpu_pkg;

    localparam int unsigned MULDIV_ITER = 32;

    typedef enum logic [1:0] {
        OpMult  = 2'd0,
        OpMultu = 2'd1,
        OpDiv   = 2'd2,
        OpDivu  = 2'd3
    } muldiv_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2
    } muldiv_state_e;

endpackage

// File: rtl/mips_cpu_div_step.sv
// One combinational restoring-divide iteration on a packed {remainder, quotient} pair.
module mips_cpu_div_step
    import mips_cpu_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_ITER
) (
    input  logic [2*WIDTH-1:0] rq,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH-1:0] rq_next
);

    logic [WIDTH:0] shifted_rem;
    logic [WIDTH:0] trial;

    // Remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits.
    assign shifted_rem = rq[2*WIDTH-1:WIDTH-1];
    assign trial       = shifted_rem - {1'b0, divisor};

    always_comb begin
        rq_next = {shifted_rem[WIDTH-1:0], rq[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rq_next = {trial[WIDTH-1:0], rq[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mips_cpu_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MTHI/MTLO and MFHI/MFLO stall.
// Define MULDIV_FAST_MULT_EN for a single-cycle combinational multiply path.
module mips_cpu_muldiv_seq
    import mips_cpu_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             mf_req,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);

    muldiv_state_e     state_q, state_d;
    muldiv_op_e        op_q, op_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic              dbz_q, dbz_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;

    muldiv_op_e        op_in;
    logic              in_signed, in_div;
    logic [WIDTH-1:0]  mag_a, mag_b;
    logic [WIDTH:0]    mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]  quot, rem;
    logic              run_div;

    assign op_in     = muldiv_op_e'(op);
    assign in_signed = (op_in == OpMult) || (op_in == OpDiv);
    assign in_div    = (op_in == OpDiv) || (op_in == OpDivu);
    assign mag_a     = (in_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign mag_b     = (in_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    assign run_div   = (op_q == OpDiv) || (op_q == OpDivu);

    // Shift-add: acc holds {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    mips_cpu_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rq      (acc_q),
        .divisor (mcand_q),
        .rq_next (div_next)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        dbz_d    = dbz_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        product  = acc_q;
        quot     = acc_q[WIDTH-1:0];
        rem      = acc_q[2*WIDTH-1:WIDTH];

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d     = op_in;
                    sign_a_d = in_signed & op_a[WIDTH-1];
                    sign_b_d = in_signed & op_b[WIDTH-1];
                    count_d  = CW'(WIDTH - 1);
                    dbz_d    = 1'b0;
                    if (in_div && (op_b == '0)) begin
                        dbz_d   = 1'b1;
                        acc_d   = {op_a, {WIDTH{1'b1}}};
                        state_d = StFix;
                    end else if (in_div) begin
                        acc_d   = {{WIDTH{1'b0}}, mag_a};
                        mcand_d = mag_b;
                        state_d = StRun;
                    end else begin
`ifdef MULDIV_FAST_MULT_EN
                        acc_d   = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
                        state_d = StFix;
`else
                        acc_d   = {{WIDTH{1'b0}}, mag_b};
                        mcand_d = mag_a;
                        state_d = StRun;
`endif
                    end
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            StRun: begin
                acc_d   = run_div ? div_next : mul_next;
                count_d = count_q - CW'(1);
                if (count_q == '0) state_d = StFix;
            end
            StFix: begin
                state_d = StIdle;
                if (dbz_q) begin
                    hi_d = acc_q[2*WIDTH-1:WIDTH];
                    lo_d = acc_q[WIDTH-1:0];
                end else if (!run_div) begin
                    if (sign_a_q ^ sign_b_q) product = -acc_q;
                    hi_d = product[2*WIDTH-1:WIDTH];
                    lo_d = product[WIDTH-1:0];
                end else begin
                    if (sign_a_q ^ sign_b_q) quot = -acc_q[WIDTH-1:0];
                    if (sign_a_q) rem = -acc_q[2*WIDTH-1:WIDTH];
                    hi_d = rem;
                    lo_d = quot;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            op_q     <= OpMult;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dbz_q    <= 1'b0;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            dbz_q    <= dbz_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy  = (state_q != StIdle);
    assign stall = mf_req && busy;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// Directed self-checking bench for mips_cpu_muldiv_seq (default build, WIDTH=32).
module tb_mips_cpu_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] op_a, op_b;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        mf_req;
    logic        busy, stall;
    logic [31:0] hi, lo;

    int checks;
    int failures;
    int n;

    mips_cpu_muldiv_seq #(
        .WIDTH (32)
    ) dut (
        .clk    (clk),
        .reset  (rst_n),
        .start  (start),
        .op     (op),
        .op_a   (op_a),
        .op_b   (op_b),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .mf_req (mf_req),
        .busy   (busy),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, verify HI/LO hold during the run, then verify latency and result.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic wr, input logic [31:0] old_hi,
                         input logic [31:0] old_lo, input int exp_cyc,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = o; op_a = a; op_b = b;
        hi_we = wr; lo_we = wr; wdata = 32'h0000_DEAD;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        check({tag, ":busy0"}, {31'd0, busy}, 32'd1);
        check({tag, ":hold_hi"}, hi, old_hi);
        check({tag, ":hold_lo"}, lo, old_lo);
        cyc = 0;
        while (busy && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 16 && busy) check({tag, ":mid_lo"}, lo, old_lo);
        end
        check({tag, ":cycles"}, cyc, exp_cyc);
        check({tag, ":hi"}, hi, exp_hi);
        check({tag, ":lo"}, lo, exp_lo);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; start = 1'b0; op = 2'd0; op_a = '0; op_b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0; mf_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        mf_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // MTHI and MTLO together in IDLE
        @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55;
        @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
        check("mt_hi", hi, 32'h55);
        check("mt_lo", lo, 32'h55);

        // start with concurrent writes: writes dropped
        do_op("divu77_11", 2'd3, 32'd77, 32'd11, 1'b1, 32'h55, 32'h55, 33, 32'd0, 32'd7);
        do_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, 32'd7, 33,
              32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF,
              32'hFFFF_FFFD, 33, 32'd0, 32'h8000_0000);
        do_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 33,
              32'hFFFF_FFFE, 32'h0000_0001);
        do_op("mult_m3_5", 2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 32'hFFFF_FFFE, 32'd1, 33,
              32'hFFFF_FFFF, 32'hFFFF_FFF1);
        do_op("divu_by0", 2'd3, 32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1,
              32'h1234, 32'hFFFF_FFFF);

        // Stall tracking with MFHI held, and MTLO ignored while busy
        @(negedge clk);
        mf_req = 1'b1; start = 1'b1; op = 2'd2; op_a = 32'd100; op_b = 32'hFFFF_FFF9;
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            check("stall_busy", {31'd0, stall}, 32'd1);
            if (n == 5) begin
                lo_we = 1'b1; wdata = 32'hAB;
            end
            @(posedge clk); #1;
            lo_we = 1'b0;
            n++;
            if (n == 6) check("mtlo_busy_ign", lo, 32'hFFFF_FFFF);
        end
        check("div100_m7:cycles", n, 33);
        check("div100_m7:stall_drop", {31'd0, stall}, 32'd0);
        check("div100_m7:hi", hi, 32'd2);
        check("div100_m7:lo", lo, 32'hFFFF_FFF2);
        mf_req = 1'b0;

        @(negedge clk); lo_we = 1'b1; wdata = 32'hAB;
        @(posedge clk); #1; lo_we = 1'b0;
        check("mtlo_idle", lo, 32'hAB);
        check("mtlo_idle_hi", hi, 32'd2);

        // Reset asserted in the middle of a run
        @(negedge clk); start = 1'b1; op = 2'd1; op_a = 32'd3; op_b = 32'd4; mf_req = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_hi", hi, 32'd0);
        check("mid_rst_lo", lo, 32'd0);
        mf_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        do_op("post_rst_divu", 2'd3, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 33, 32'd2, 32'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_cpu_muldiv_seq.md
# mips_cpu_muldiv_seq

Iterative multiply/divide sequencer owning the HI/LO register pair of `mips_cpu_harvard`. It accepts MULT/MULTU/DIV/DIVU from the decode stage and runs a radix-2 shift-add or restoring-divide loop over WIDTH cycles. It writes HI/LO on completion and stalls MFHI/MFLO until the result is ready. It also services MTHI/MTLO.

## Interface
Parameters:
- WIDTH, 32, operand width; HI/LO each WIDTH bits; iteration count = WIDTH

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin op; sampled only in IDLE
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- op_a  in  WIDTH  rs (multiplicand / dividend)
- op_b  in  WIDTH  rt (multiplier / divisor)
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wdata  in  WIDTH  MTHI/MTLO data
- mf_req  in  1  decode holds MFHI/MFLO
- busy  out  1  operation in progress
- stall  out  1  mf_req && busy, combinational
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- States: IDLE, RUN, FIX.
- IDLE + start:
  - latch |op_a| and |op_b| (magnitudes for signed ops; raw values for unsigned ops).
  - latch sign flags.
  - count = WIDTH-1.
  - go to RUN.
- RUN, multiply: 2*WIDTH accumulator; add multiplicand if multiplier LSB=1, shift right 1. Count decrements; at 0 go to FIX.
- RUN, divide: restoring; shift {rem,quot} left 1, trial-subtract divisor, keep if non-negative and set quotient bit. Same count rule.
- FIX:
  - Signed mult: negate product if sign_a^sign_b. HI=product[2W-1:W], LO=product[W-1:0].
  - Signed div: quotient negated if sign_a^sign_b; remainder takes sign of op_a. LO=quotient, HI=remainder.
  - Go to IDLE.
- Divide by zero (op_b==0, DIV or DIVU): skip RUN (IDLE→FIX). HI=op_a (raw), LO={WIDTH{1}}.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (falls out of the magnitude path).
- MTHI/MTLO: in IDLE, hi_we/lo_we write at the edge. Both writes may occur in the same cycle.
- Requests ignored while busy: start, hi_we, lo_we (CPU already stalled).
- start together with hi_we/lo_we in IDLE: start wins; writes dropped.
- HI/LO hold their old values through RUN and change only at the FIX edge.

## Timing
- Reset clears state to IDLE and sets hi, lo, busy, stall, and all internal registers to 0.
- Reset asserted mid-operation aborts immediately with no partial HI/LO update.
- Start accepted at edge E0. busy=1 from after E0 until after E0+WIDTH+1; new HI/LO visible after edge E0+WIDTH+1 (33 cycles for WIDTH=32).
- Divide by zero: result after E0+1.
- busy falls in the same edge HI/LO update, so an MFHI stalled on busy reads the new value the following cycle.
- stall has no register; it follows busy within the cycle.

## Configuration
- MULDIV_FAST_MULT_EN defined: MULT/MULTU compute a full combinational product at start and go IDLE→FIX; result after E0+1. DIV/DIVU unchanged.
- MULDIV_FAST_MULT_EN undefined: MULT/MULTU use the WIDTH-cycle shift-add loop.

## Structure
- Shared package `mips_cpu_pkg` holds:
  - op encoding enum: MULT, MULTU, DIV, DIVU
  - state enum: IDLE, RUN, FIX
  - constant MULDIV_ITER = 32
- One sub-module: `mips_cpu_div_step`, a combinational single restoring-divide iteration ({rem,quot},divisor → next {rem,quot}), instantiated once.

## Test plan
- DIVU 77 / 11 → after 33 cycles LO=7, HI=0; busy high exactly 33 cycles.
- DIV 0xFFFFFFF9 (-7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; MULT 0xFFFFFFFD × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIVU 0x1234 / 0 → after 1 cycle HI=0x1234, LO=0xFFFFFFFF.
- mf_req held during DIV → stall=1 every busy cycle, drops with busy; MTLO 0xAB during RUN ignored, MTLO 0xAB in IDLE → LO=0xAB.
- reset pulled low at RUN cycle 10 → immediately busy=0, hi=lo=0, IDLE; fresh start after release completes normally.
